mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/grande_risco5_pkg.sv | 20 ++
 rtl/arb_priority_select.sv | 22 ++
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grande_risco5_pkg.sv
// Shared definitions for the grande_risco5 memory subsystem: arbiter state
// encoding, default arbiter constants and a counter-width helper.
package grande_risco5_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam int ARB_STARVE_LIMIT_DEFAULT   = 4;
    localparam int ARB_TIMEOUT_CYCLES_DEFAULT = 255;

    // Bits needed to hold every value from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_priority_select.sv
// Arbitration decision for mem_arbiter: the D-cache wins a tie unless the
// I-cache has already been passed over STARVE_LIMIT times in a row.
module arb_priority_select
    import grande_risco5_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT,
    parameter int CNT_WIDTH    = cnt_width(STARVE_LIMIT)
) (
    input  logic                 i_req_i,
    input  logic                 d_req_i,
    input  logic [CNT_WIDTH-1:0] starve_cnt_i,
    output logic                 grant_i_o,
    output logic                 grant_d_o
);

    logic starved;

    assign starved   = (starve_cnt_i == CNT_WIDTH'(STARVE_LIMIT));
    assign grant_i_o = i_req_i && (!d_req_i || starved);
    assign grant_d_o = d_req_i && !grant_i_o;

endmodule

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter (I-cache / D-cache) with starvation protection.
// Define MEM_ARBITER_TIMEOUT_EN to add a grant timeout that pulses bus_error.
module mem_arbiter
    import grande_risco5_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STARVE_LIMIT   = ARB_STARVE_LIMIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_cache_read_request,
    input  logic [ADDR_WIDTH-1:0] i_cache_address,
    output logic [DATA_WIDTH-1:0] i_cache_read_data,
    output logic                  i_cache_response,
    input  logic                  d_cache_read_request,
    input  logic                  d_cache_write_request,
    input  logic [ADDR_WIDTH-1:0] d_cache_address,
    input  logic [DATA_WIDTH-1:0] d_cache_write_data,
    output logic [DATA_WIDTH-1:0] d_cache_read_data,
    output logic                  d_cache_response,
    output logic                  memory_read_request,
    output logic                  memory_write_request,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    output logic [DATA_WIDTH-1:0] memory_write_data,
    input  logic                  memory_response,
    input  logic [DATA_WIDTH-1:0] memory_read_data,
    output logic                  bus_error,
    output logic [1:0]            grant_owner
);

    localparam int SW = cnt_width(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e            state_q, state_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;

    logic d_req;
    logic grant_i;
    logic grant_d;
    logic in_grant;
    logic mem_done;
    logic timed_out;
    logic finish;

    assign d_req    = d_cache_read_request | d_cache_write_request;
    assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);
    assign mem_done = in_grant && memory_response;
    assign finish   = mem_done || timed_out;

    arb_priority_select #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_WIDTH    (SW)
    ) u_prio (
        .i_req_i      (i_cache_read_request),
        .d_req_i      (d_req),
        .starve_cnt_i (starve_q),
        .grant_i_o    (grant_i),
        .grant_d_o    (grant_d)
    );

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_err_q;

    // Fires in the TIMEOUT_CYCLES-th grant cycle that still has no response.
    assign timed_out = in_grant && !memory_response && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign tmo_d     = in_grant ? tmo_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            bus_err_q <= timed_out;
        end
    end

    assign bus_error = bus_err_q;
`else
    assign timed_out = 1'b0;
    assign bus_error = 1'b0;
`endif

    // NOTE: reset is sampled on the clock edge only; it never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = GRANT_I;
                end else if (grant_d) begin
                    state_d = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (finish) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        memory_read_request  = 1'b0;
        memory_write_request = 1'b0;
        if (in_grant) begin
            memory_read_request  = !is_write_q;
            memory_write_request = is_write_q;
        end
    end

    assign grant_owner       = state_q;
    assign memory_addr       = addr_q;
    assign memory_write_data = wdata_q;
    assign i_cache_read_data = i_rdata_q;
    assign d_cache_read_data = d_rdata_q;
    assign i_cache_response  = i_resp_q;
    assign d_cache_response  = d_resp_q;

    // Request capture, starvation bookkeeping and response pulses.
    always_comb begin
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_resp_d   = 1'b0;
        d_resp_d   = 1'b0;

        if (state_q == IDLE) begin
            if (grant_i || !i_cache_read_request) begin
                starve_d = '0;
            end else if (grant_d && (starve_q != SW'(STARVE_LIMIT))) begin
                starve_d = starve_q + 1'b1;
            end

            if (grant_i) begin
                addr_d     = i_cache_address;
                is_write_d = 1'b0;
            end else if (grant_d) begin
                addr_d     = d_cache_address;
                wdata_d    = d_cache_write_data;
                is_write_d = d_cache_write_request;
            end
        end

        if (finish) begin
            if (state_q == GRANT_I) begin
                i_resp_d  = 1'b1;
                i_rdata_d = timed_out ? '0 : memory_read_data;
            end else begin
                d_resp_d  = 1'b1;
                d_rdata_d = timed_out ? '0 : memory_read_data;
            end
        end
    end

    // The holding registers drive ports directly, so they are reset along with the FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_resp_q   <= 1'b0;
            d_resp_q   <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_resp_q   <= i_resp_d;
            d_resp_q   <= d_resp_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// two-client traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SL = 4;
    localparam int TC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_cache_read_request = 1'b0;
    logic [AW-1:0] i_cache_address = '0;
    logic [DW-1:0] i_cache_read_data;
    logic          i_cache_response;
    logic          d_cache_read_request = 1'b0;
    logic          d_cache_write_request = 1'b0;
    logic [AW-1:0] d_cache_address = '0;
    logic [DW-1:0] d_cache_write_data = '0;
    logic [DW-1:0] d_cache_read_data;
    logic          d_cache_response;
    logic          memory_read_request;
    logic          memory_write_request;
    logic [AW-1:0] memory_addr;
    logic [DW-1:0] memory_write_data;
    logic          memory_response = 1'b0;
    logic [DW-1:0] memory_read_data = '0;
    logic          bus_error;
    logic [1:0]    grant_owner;

    int errors = 0;
    int checks = 0;

    // Reference model: pending client requests, starvation streak, last delivered data.
    bit            i_pend, d_pend, d_wr, d_rd_too;
    logic [AW-1:0] i_addr_m, d_addr_m;
    logic [DW-1:0] d_wdata_m, last_i_rd, last_d_rd;
    int            streak;
    bit            grant_log[$];
    bit            exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    mem_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .STARVE_LIMIT   (SL),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .i_cache_read_request  (i_cache_read_request),
        .i_cache_address       (i_cache_address),
        .i_cache_read_data     (i_cache_read_data),
        .i_cache_response      (i_cache_response),
        .d_cache_read_request  (d_cache_read_request),
        .d_cache_write_request (d_cache_write_request),
        .d_cache_address       (d_cache_address),
        .d_cache_write_data    (d_cache_write_data),
        .d_cache_read_data     (d_cache_read_data),
        .d_cache_response      (d_cache_response),
        .memory_read_request   (memory_read_request),
        .memory_write_request  (memory_write_request),
        .memory_addr           (memory_addr),
        .memory_write_data     (memory_write_data),
        .memory_response       (memory_response),
        .memory_read_data      (memory_read_data),
        .bus_error             (bus_error),
        .grant_owner           (grant_owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_owner"}, 64'(grant_owner), 64'(0));
        check({tag, "_mem_rd"}, 64'(memory_read_request), 64'(0));
        check({tag, "_mem_wr"}, 64'(memory_write_request), 64'(0));
        check({tag, "_mem_addr"}, 64'(memory_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(memory_write_data), 64'(0));
        check({tag, "_i_resp"}, 64'(i_cache_response), 64'(0));
        check({tag, "_d_resp"}, 64'(d_cache_response), 64'(0));
        check({tag, "_i_rdata"}, 64'(i_cache_read_data), 64'(0));
        check({tag, "_d_rdata"}, 64'(d_cache_read_data), 64'(0));
        check({tag, "_bus_error"}, 64'(bus_error), 64'(0));
    endtask

    task automatic drive_requests();
        i_cache_read_request  = i_pend;
        i_cache_address       = i_addr_m;
        d_cache_read_request  = d_pend && (!d_wr || d_rd_too);
        d_cache_write_request = d_pend && d_wr;
        d_cache_address       = d_addr_m;
        d_cache_write_data    = d_wdata_m;
    endtask

    task automatic apply_reset();
        reset           = 1'b0;
        memory_response = 1'b0;
        i_pend          = 1'b0;
        d_pend          = 1'b0;
        streak          = 0;
        last_i_rd       = '0;
        last_d_rd       = '0;
        drive_requests();
        step();
        step();
        check_all_zero("reset");
        reset = 1'b1;
    endtask

    // Random traffic: each client raises a request with probability pct% per cycle
    // while idle and holds it until its response pulse; memory answers after 1..4 cycles.
    task automatic run_traffic(input int ncycles, input int pct);
        bit            busy = 1'b0;
        bit            pulse = 1'b0;
        bit            own_d = 1'b0;
        bit            t_wr = 1'b0;
        logic [AW-1:0] t_addr = '0;
        logic [DW-1:0] t_wdata = '0;
        logic [DW-1:0] t_rdata = '0;
        int            lat = 0;
        int            k = 0;
        for (int c = 0; c < ncycles; c++) begin
            step();
            if (pulse) begin
                check("tr_rel_owner", 64'(grant_owner), 64'(3));
                check("tr_rel_mem_req", 64'({memory_read_request, memory_write_request}), 64'(0));
                check("tr_i_resp", 64'(i_cache_response), 64'(!own_d));
                check("tr_d_resp", 64'(d_cache_response), 64'(own_d));
                if (own_d) begin
                    last_d_rd = t_rdata;
                    d_pend    = 1'b0;
                end else begin
                    last_i_rd = t_rdata;
                    i_pend    = 1'b0;
                end
            end else if (busy) begin
                if (k == 0) grant_log.push_back(grant_owner == 2'd1);
                check("tr_grant_owner", 64'(grant_owner), own_d ? 64'(2) : 64'(1));
                check("tr_mem_rd", 64'(memory_read_request), 64'(!t_wr));
                check("tr_mem_wr", 64'(memory_write_request), 64'(t_wr));
                check("tr_mem_addr", 64'(memory_addr), 64'(t_addr));
                if (t_wr) check("tr_mem_wdata", 64'(memory_write_data), 64'(t_wdata));
                check("tr_resp_quiet", 64'({i_cache_response, d_cache_response}), 64'(0));
            end else begin
                check("tr_idle_owner", 64'(grant_owner), 64'(0));
                check("tr_idle_mem_req", 64'({memory_read_request, memory_write_request}), 64'(0));
                check("tr_idle_resp", 64'({i_cache_response, d_cache_response}), 64'(0));
            end
            check("tr_i_rdata", 64'(i_cache_read_data), 64'(last_i_rd));
            check("tr_d_rdata", 64'(d_cache_read_data), 64'(last_d_rd));
            check("tr_bus_error", 64'(bus_error), 64'(0));

            memory_response = 1'b0;
            if (busy && !pulse) begin
                k++;
                if (k == lat) begin
                    memory_response  = 1'b1;
                    memory_read_data = t_rdata;
                end
            end else if ($urandom_range(3) == 0) begin
                memory_response  = 1'b1;
                memory_read_data = $urandom;
            end

            if (!i_pend && ($urandom_range(99) < 32'(pct))) begin
                i_pend   = 1'b1;
                i_addr_m = $urandom;
            end
            if (!d_pend && ($urandom_range(99) < 32'(pct))) begin
                d_pend    = 1'b1;
                d_wr      = 1'($urandom_range(1));
                d_rd_too  = 1'($urandom_range(1));
                d_addr_m  = $urandom;
                d_wdata_m = $urandom;
            end
            drive_requests();

            if (pulse) begin
                pulse = 1'b0;
                busy  = 1'b0;
            end else if (busy) begin
                if (k == lat) pulse = 1'b1;
            end else if (i_pend || d_pend) begin
                if (!i_pend) streak = 0;
                own_d = d_pend && !(i_pend && streak == SL);
                if (own_d) begin
                    if (i_pend && streak < SL) streak++;
                    t_wr    = d_wr;
                    t_addr  = d_addr_m;
                    t_wdata = d_wdata_m;
                end else begin
                    streak = 0;
                    t_wr   = 1'b0;
                    t_addr = i_addr_m;
                end
                t_rdata = $urandom;
                lat     = $urandom_range(4, 1);
                k       = 0;
                busy    = 1'b1;
            end else begin
                streak = 0;
            end
        end
    endtask

    initial begin
        apply_reset();

        // Single I-cache read of 0x100, memory answers in the second grant cycle.
        i_cache_read_request = 1'b1;
        i_cache_address      = 32'h100;
        step();
        check("i_owner", 64'(grant_owner), 64'(1));
        check("i_mem_rd", 64'(memory_read_request), 64'(1));
        check("i_mem_wr", 64'(memory_write_request), 64'(0));
        check("i_mem_addr", 64'(memory_addr), 64'h100);
        memory_read_data = 32'hDEADBEEF;
        step();
        check("i_mem_rd_held", 64'(memory_read_request), 64'(1));
        check("i_no_early_resp", 64'(i_cache_response), 64'(0));
        memory_response = 1'b1;
        step();
        check("i_resp_pulse", 64'(i_cache_response), 64'(1));
        check("i_resp_data", 64'(i_cache_read_data), 64'hDEADBEEF);
        check("i_release_owner", 64'(grant_owner), 64'(3));
        check("i_release_mem_rd", 64'(memory_read_request), 64'(0));
        check("i_other_resp", 64'(d_cache_response), 64'(0));
        memory_response      = 1'b0;
        i_cache_read_request = 1'b0;
        step();
        check("i_resp_one_cycle", 64'(i_cache_response), 64'(0));
        check("i_back_idle", 64'(grant_owner), 64'(0));
        check("i_data_held", 64'(i_cache_read_data), 64'hDEADBEEF);

        // Stray memory response while idle must not produce a response pulse.
        memory_response  = 1'b1;
        memory_read_data = 32'hBAD0BAD0;
        step();
        check("stray_owner", 64'(grant_owner), 64'(0));
        check("stray_resp", 64'({i_cache_response, d_cache_response}), 64'(0));
        memory_response = 1'b0;
        step();
        check("stray_resp_late", 64'({i_cache_response, d_cache_response}), 64'(0));
        check("stray_data_held", 64'(i_cache_read_data), 64'hDEADBEEF);

        // D-cache write of 0x12345678 to 0x200; read line also high so the write must win.
        d_cache_write_request = 1'b1;
        d_cache_read_request  = 1'b1;
        d_cache_address       = 32'h200;
        d_cache_write_data    = 32'h12345678;
        step();
        check("dw_owner", 64'(grant_owner), 64'(2));
        for (int j = 0; j < 4; j++) begin
            check("dw_mem_wr", 64'(memory_write_request), 64'(1));
            check("dw_mem_rd", 64'(memory_read_request), 64'(0));
            check("dw_mem_addr", 64'(memory_addr), 64'h200);
            check("dw_mem_wdata", 64'(memory_write_data), 64'h12345678);
            check("dw_i_resp", 64'(i_cache_response), 64'(0));
            if (j < 3) step();
        end
        memory_read_data = 32'hCAFEF00D;
        memory_response  = 1'b1;
        step();
        check("dw_resp", 64'(d_cache_response), 64'(1));
        check("dw_i_resp_rel", 64'(i_cache_response), 64'(0));
        check("dw_rel_mem_wr", 64'(memory_write_request), 64'(0));
        check("dw_resp_data", 64'(d_cache_read_data), 64'hCAFEF00D);
        memory_response       = 1'b0;
        d_cache_write_request = 1'b0;
        d_cache_read_request  = 1'b0;
        step();
        check("dw_back_idle", 64'(grant_owner), 64'(0));

        // D read that memory never answers.
        d_cache_read_request = 1'b1;
        d_cache_address      = 32'h300;
        memory_read_data     = 32'hFFFF0000;
        step();
        check("to_owner", 64'(grant_owner), 64'(2));
`ifdef MEM_ARBITER_TIMEOUT_EN
        for (int j = 2; j <= TC; j++) begin
            step();
            check("to_wait_owner", 64'(grant_owner), 64'(2));
            check("to_wait_resp", 64'(d_cache_response), 64'(0));
            check("to_wait_bus_error", 64'(bus_error), 64'(0));
        end
        step();
        check("to_resp", 64'(d_cache_response), 64'(1));
        check("to_resp_data", 64'(d_cache_read_data), 64'(0));
        check("to_bus_error", 64'(bus_error), 64'(1));
        check("to_release", 64'(grant_owner), 64'(3));
        d_cache_read_request = 1'b0;
        step();
        check("to_bus_error_once", 64'(bus_error), 64'(0));
        check("to_resp_once", 64'(d_cache_response), 64'(0));
        check("to_idle", 64'(grant_owner), 64'(0));
`else
        for (int j = 0; j < 20; j++) begin
            step();
            check("wait_owner", 64'(grant_owner), 64'(2));
            check("wait_mem_rd", 64'(memory_read_request), 64'(1));
            check("wait_resp", 64'(d_cache_response), 64'(0));
            check("wait_bus_error", 64'(bus_error), 64'(0));
        end
        memory_read_data = 32'h55AA55AA;
        memory_response  = 1'b1;
        step();
        check("wait_resp_pulse", 64'(d_cache_response), 64'(1));
        check("wait_resp_data", 64'(d_cache_read_data), 64'h55AA55AA);
        memory_response      = 1'b0;
        d_cache_read_request = 1'b0;
        step();
        check("wait_idle", 64'(grant_owner), 64'(0));
`endif

        // Reset asserted in the middle of a D grant aborts it silently.
        d_cache_read_request = 1'b1;
        d_cache_address      = 32'h400;
        step();
        check("mid_owner", 64'(grant_owner), 64'(2));
        reset = 1'b0;
        step();
        check_all_zero("mid_reset");
        reset                = 1'b1;
        d_cache_read_request = 1'b0;
        memory_response      = 1'b1;
        memory_read_data     = 32'h77;
        step();
        check("mid_late_resp", 64'({i_cache_response, d_cache_response}), 64'(0));
        check("mid_owner_idle", 64'(grant_owner), 64'(0));
        memory_response = 1'b0;
        step();
        check("mid_late_resp2", 64'({i_cache_response, d_cache_response}), 64'(0));
        check("mid_data_zero", 64'(d_cache_read_data), 64'(0));

        // Both clients request continuously: starvation protection sets the grant order.
        apply_reset();
        grant_log.delete();
        run_traffic(80, 100);
        check("starve_log_len", 64'(grant_log.size() >= 10), 64'(1));
        if (grant_log.size() >= 10) begin
            for (int j = 0; j < 10; j++) begin
                check("starve_order", 64'(grant_log[j]), 64'(exp_order[j]));
            end
        end

        // Mixed random traffic.
        apply_reset();
        run_traffic(3000, 35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
